// File: rtl/puertas_pkg.sv
// Shared door encodings for the door actuator and the door controller.
// The door status encoding is also the actuator's state register, so the
// controller can read the state directly without any translation.
// Contents:
//   puertas_e  - 2-bit door status / actuator state
//   CMD_*      - 2-bit door command values driven by the controller
package puertas_pkg;

  typedef enum logic [1:0] {
    PUERTAS_CERRADAS = 2'b00,
    PUERTAS_ABIERTAS = 2'b01,
    PUERTAS_CERRANDO = 2'b10,
    PUERTAS_ABRIENDO = 2'b11
  } puertas_e;

  localparam logic [1:0] CMD_NADA   = 2'b00;
  localparam logic [1:0] CMD_ABRIR  = 2'b01;
  localparam logic [1:0] CMD_CERRAR = 2'b10;

endpackage

// File: rtl/filtro_sensor.sv
// Obstruction sensor conditioning: a 2-flop synchronizer followed by a
// 2-sample agreement filter. The filtered output only changes when two
// consecutive synchronized samples agree, so a single-cycle glitch never
// reaches the door mechanism. From a sensor edge, the filtered level changes
// three clock edges later. All flops reset to 0 (no obstruction).
// Ports:
//   clk         - system clock, rising edge
//   rst_n       - asynchronous active-low reset
//   sensor_i    - raw obstruction sensor, 1 = sensed
//   sensor_ef_o - filtered obstruction level
module filtro_sensor (
  input  logic clk,
  input  logic rst_n,
  input  logic sensor_i,
  output logic sensor_ef_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic filt_q;
  logic filt_d;

  // Agreement decode: follow the synchronized level once two consecutive
  // samples match, otherwise keep the last agreed value.
  always_comb begin
    filt_d = filt_q;
    if (sync2_q == prev_q) begin
      filt_d = sync2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      filt_q  <= 1'b0;
    end else begin
      sync1_q <= sensor_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      filt_q  <= filt_d;
    end
  end

  assign sensor_ef_o = filt_d;

endmodule

// File: rtl/actuador_puertas.sv
// Door mechanism and open-hold timer. Follows the controller's door command,
// models a finite travel time, reverses when an obstruction is sensed while
// closing, and times how long the doors remain fully open.
// Optional build macro: PUERTAS_FILTRO_SENSOR_EN adds a synchronizer and
// agreement filter on the obstruction sensor; otherwise the raw sensor acts
// in the same cycle.
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - asynchronous active-low reset
//   comando  - door command: 01 open, 10 close, 00/11 nothing
//   sensor   - obstruction between doors, 1 = sensed
//   puertas  - door status: 00 closed, 01 open, 10 closing, 11 opening
//   timeout  - doors fully open and hold timer expired (level)
//   posicion - opening position, 0 = closed, T_MOVER = fully open
module actuador_puertas
  import puertas_pkg::*;
#(
  parameter int T_MOVER   = 8,
  parameter int T_ABIERTA = 50,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       comando,
  input  logic             sensor,
  output logic [1:0]       puertas,
  output logic             timeout,
  output logic [CNT_W-1:0] posicion
);

  localparam logic [CNT_W-1:0] MOVER_C   = CNT_W'(T_MOVER);
  localparam logic [CNT_W-1:0] MOVER_M1  = CNT_W'(T_MOVER - 1);
  localparam logic [CNT_W-1:0] ABIERTA_C = CNT_W'(T_ABIERTA);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  puertas_e         estado_q;
  logic [CNT_W-1:0] posicion_q;
  logic [CNT_W-1:0] timer_q;
  logic             sensorEf;

`ifdef PUERTAS_FILTRO_SENSOR_EN
  filtro_sensor u_filtro_sensor (
    .clk         (clk),
    .rst_n       (rst_n),
    .sensor_i    (sensor),
    .sensor_ef_o (sensorEf)
  );
`else
  assign sensorEf = sensor;
`endif

  // Door state machine. The state register is the door status itself.
  // Obstruction always wins over a close request. Reversals keep the
  // position so the return trip takes as long as the distance covered.
  // The travel-end checks use >= / <= so a reversal right at an end stop
  // finishes cleanly instead of wrapping the position counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q   <= PUERTAS_CERRADAS;
      posicion_q <= '0;
      timer_q    <= '0;
    end else begin
      case (estado_q)
        PUERTAS_CERRADAS: begin
          timer_q <= '0;
          if (comando == CMD_ABRIR) begin
            estado_q <= PUERTAS_ABRIENDO;
          end
        end
        PUERTAS_ABRIENDO: begin
          timer_q <= '0;
          if (comando == CMD_CERRAR && !sensorEf) begin
            estado_q <= PUERTAS_CERRANDO;
          end else if (posicion_q >= MOVER_M1) begin
            posicion_q <= MOVER_C;
            estado_q   <= PUERTAS_ABIERTAS;
          end else begin
            posicion_q <= posicion_q + ONE_C;
          end
        end
        PUERTAS_ABIERTAS: begin
          if (comando == CMD_CERRAR && !sensorEf) begin
            estado_q <= PUERTAS_CERRANDO;
            timer_q  <= '0;
          end else if (comando == CMD_ABRIR || sensorEf) begin
            timer_q <= '0;
          end else if (timer_q != ABIERTA_C) begin
            timer_q <= timer_q + ONE_C;
          end
        end
        PUERTAS_CERRANDO: begin
          timer_q <= '0;
          if (sensorEf || comando == CMD_ABRIR) begin
            estado_q <= PUERTAS_ABRIENDO;
          end else if (posicion_q <= ONE_C) begin
            posicion_q <= '0;
            estado_q   <= PUERTAS_CERRADAS;
          end else begin
            posicion_q <= posicion_q - ONE_C;
          end
        end
        default: begin
          estado_q   <= PUERTAS_CERRADAS;
          posicion_q <= '0;
          timer_q    <= '0;
        end
      endcase
    end
  end

  assign puertas  = estado_q;
  assign posicion = posicion_q;
  assign timeout  = (estado_q == PUERTAS_ABIERTAS) && (timer_q == ABIERTA_C);

endmodule

// File: tb/tb_actuador_puertas.sv
// Self-checking bench for actuador_puertas with T_MOVER=4, T_ABIERTA=6.
// Default build: a table of directed vectors, an asynchronous reset during
// travel, and a randomized run against a behavioural door model.
// With PUERTAS_FILTRO_SENSOR_EN: glitch rejection and filtered reversal.
module tb_actuador_puertas;

   localparam int TM = 4;
   localparam int TA = 6;
   localparam int CW = 8;

   logic          clk;
   logic          rst_n;
   logic [1:0]    comando;
   logic          sensor;
   logic [1:0]    puertas;
   logic          timeout;
   logic [CW-1:0] posicion;

   int checks;
   int errors;

   actuador_puertas #(.T_MOVER(TM), .T_ABIERTA(TA), .CNT_W(CW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .comando  (comando),
      .sensor   (sensor),
      .puertas  (puertas),
      .timeout  (timeout),
      .posicion (posicion)
   );

   // 10-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      int cmd;
      int sen;
      int expP;
      int expPos;
      int expT;
   } vec_t;

   // Drive one cycle of inputs and sample just after the clock edge
   task automatic applyStimulus(input int cmd, input int sen);
      comando = cmd[1:0];
      sensor  = sen[0];
      @(posedge clk);
      #1;
   endtask

   // Compare all three outputs against required values
   task automatic checkOutput(input string name, input int expP, input int expPos, input int expT);
      checks++;
      if (int'(puertas) != expP || int'(posicion) != expPos || int'(timeout) != expT) begin
         errors++;
         $display("[TB] FAIL %s: got puertas=%0d posicion=%0d timeout=%0d, required puertas=%0d posicion=%0d timeout=%0d",
                  name, puertas, posicion, timeout, expP, expPos, expT);
      end
   endtask

   task automatic doReset();
      rst_n   = 1'b0;
      comando = 2'b00;
      sensor  = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Behavioural door model: mode 0 closed, 1 opening, 2 open, 3 closing
   int mMode;
   int mPos;
   int mHold;

   function automatic int modelStatus(input int mode);
      case (mode)
         1:       return 3;
         2:       return 1;
         3:       return 2;
         default: return 0;
      endcase
   endfunction

   task automatic modelStep(input int cmd, input int sen);
      bit wantOpen;
      bit wantClose;
      wantOpen  = (cmd == 1);
      wantClose = (cmd == 2) && (sen == 0);
      if (mMode == 0) begin
         if (wantOpen) mMode = 1;
      end else if (mMode == 1) begin
         if (wantClose) mMode = 3;
         else begin
            mPos = (mPos + 1 >= TM) ? TM : mPos + 1;
            if (mPos == TM) mMode = 2;
         end
      end else if (mMode == 2) begin
         if (wantClose) mMode = 3;
         else if (wantOpen || sen != 0) mHold = 0;
         else mHold = (mHold + 1 > TA) ? TA : mHold + 1;
      end else begin
         if (sen != 0 || wantOpen) mMode = 1;
         else begin
            mPos = (mPos - 1 <= 0) ? 0 : mPos - 1;
            if (mPos == 0) mMode = 0;
         end
      end
      if (mMode != 2) mHold = 0;
   endtask

`ifndef PUERTAS_FILTRO_SENSOR_EN
   vec_t vecs[32];

   initial begin
      checks = 0;
      errors = 0;
      vecs = '{
         '{1,0,3,0,0}, '{1,0,3,1,0}, '{1,0,3,2,0}, '{1,0,3,3,0}, '{1,0,1,4,0},
         '{0,0,1,4,0}, '{0,0,1,4,0}, '{0,0,1,4,0}, '{0,0,1,4,0}, '{0,0,1,4,0}, '{0,0,1,4,1},
         '{1,0,1,4,0},
         '{0,0,1,4,0}, '{0,0,1,4,0}, '{0,0,1,4,0}, '{0,0,1,4,0}, '{0,0,1,4,0}, '{0,0,1,4,1},
         '{2,1,1,4,0},
         '{2,0,2,4,0}, '{2,0,2,3,0}, '{2,0,2,2,0},
         '{2,1,3,2,0}, '{0,0,3,3,0}, '{0,0,1,4,0},
         '{2,0,2,4,0}, '{0,0,2,3,0}, '{0,0,2,2,0}, '{0,0,2,1,0}, '{0,0,0,0,0},
         '{0,1,0,0,0}, '{3,0,0,0,0}
      };

      doReset();
      checkOutput("reset", 0, 0, 0);

      for (int i = 0; i < 32; i++) begin
         applyStimulus(vecs[i].cmd, vecs[i].sen);
         checkOutput($sformatf("vec%0d", i), vecs[i].expP, vecs[i].expPos, vecs[i].expT);
      end

      // Asynchronous reset while opening at posicion=3
      applyStimulus(1, 0);
      for (int i = 0; i < 3; i++) applyStimulus(1, 0);
      checkOutput("pre_async_reset", 3, 3, 0);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset", 0, 0, 0);
      #2;
      rst_n = 1'b1;
      comando = 2'b00;
      @(posedge clk);
      #1;
      checkOutput("after_reset", 0, 0, 0);

      // Randomized run against the behavioural model
      mMode = 0;
      mPos  = 0;
      mHold = 0;
      for (int i = 0; i < 600; i++) begin
         int r;
         int cmd;
         int sen;
         r   = int'($urandom_range(0, 9));
         cmd = (r < 5) ? 0 : (r < 7) ? 1 : (r < 9) ? 2 : 3;
         sen = ($urandom_range(0, 7) == 0) ? 1 : 0;
         applyStimulus(cmd, sen);
         modelStep(cmd, sen);
         checkOutput($sformatf("rand%0d", i), modelStatus(mMode), mPos,
                     (mMode == 2 && mHold == TA) ? 1 : 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
`else
   initial begin
      checks = 0;
      errors = 0;
      doReset();
      checkOutput("reset", 0, 0, 0);

      for (int i = 0; i < 5; i++) applyStimulus(1, 0);
      checkOutput("opened", 1, 4, 0);
      applyStimulus(2, 0);
      checkOutput("closing", 2, 4, 0);

      // One-cycle glitch must not reverse the doors
      applyStimulus(0, 1);
      checkOutput("glitch_0", 2, 3, 0);
      applyStimulus(0, 0);
      checkOutput("glitch_1", 2, 2, 0);
      applyStimulus(0, 0);
      checkOutput("glitch_2", 2, 1, 0);
      applyStimulus(0, 0);
      checkOutput("glitch_3", 0, 0, 0);

      for (int i = 0; i < 5; i++) applyStimulus(1, 0);
      checkOutput("reopened", 1, 4, 0);
      applyStimulus(2, 0);
      checkOutput("closing2", 2, 4, 0);

      // Held obstruction reverses after the filter latency
      applyStimulus(0, 1);
      checkOutput("held_1", 2, 3, 0);
      applyStimulus(0, 1);
      checkOutput("held_2", 2, 2, 0);
      applyStimulus(0, 1);
      checkOutput("held_3", 2, 1, 0);
      applyStimulus(0, 1);
      checkOutput("held_reverse", 3, 1, 0);
      applyStimulus(0, 1);
      checkOutput("held_open_2", 3, 2, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
`endif

endmodule
